// File: rtl/traffic_pkg.sv
// Shared definitions for the lamp conflict monitor.
//   - Lamp encodings (one-hot red/yellow/green, plus all-dark for flashing)
//   - Monitor FSM state encoding
//   - fault_code values
//   - Helpers that classify a single 3-bit lamp command
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_PENDING = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } mon_state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_INVALID  = 2'd1;
  localparam logic [1:0] FC_CONFLICT = 2'd2;
  localparam logic [1:0] FC_STUCK    = 2'd3;

  // A lamp command is legal only if it is exactly one of the three colours.
  function automatic logic lamp_valid(input logic [2:0] l);
    return (l == RED) || (l == YELLOW) || (l == GREEN);
  endfunction

  // Yellow still lets traffic through, so it counts as active.
  function automatic logic lamp_active(input logic [2:0] l);
    return (l == YELLOW) || (l == GREEN);
  endfunction

endpackage

// File: rtl/lamp_conflict_check.sv
// Combinational classifier for one sample of the four lamp commands.
// Ports:
//   m1, m2, side, m1_turn : lamp commands (one-hot 100/010/001)
//   invalid               : some command is not exactly one colour (000 included)
//   conflict              : an incompatible pair of movements is active together
module lamp_conflict_check
  import traffic_pkg::*;
(
  input  logic [2:0] m1,
  input  logic [2:0] m2,
  input  logic [2:0] side,
  input  logic [2:0] m1_turn,
  output logic       invalid,
  output logic       conflict
);

  logic act_m1;
  logic act_m2;
  logic act_side;
  logic act_turn;

  always_comb begin
    act_m1   = lamp_active(m1);
    act_m2   = lamp_active(m2);
    act_side = lamp_active(side);
    act_turn = lamp_active(m1_turn);

    invalid  = !(lamp_valid(m1) && lamp_valid(m2) &&
                 lamp_valid(side) && lamp_valid(m1_turn));

    // M1 and M1Turn share an approach and may run together; every other
    // listed pair crosses paths.
    conflict = (act_m2 && act_turn) || (act_m1 && act_side) ||
               (act_m2 && act_side) || (act_turn && act_side);
  end

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Safety monitor between a traffic controller and the field lamps.
// Passes lamp commands through with one cycle of latency while they are sane;
// blanks to all-red on a suspicious sample, and latches a flashing fault on a
// debounced invalid/conflicting pattern or on inputs that stop changing.
// Ports:
//   clk, rst (async, active-low)
//   light_*_in  : upstream lamp commands (one-hot 100 red / 010 yellow / 001 green)
//   clr_fault   : operator clear pulse, honoured only in FAULT on a clean sample
//   light_*     : registered lamp drives
//   fault       : registered, high in FAULT and RECOVER
//   fault_code  : registered, 0 none / 1 invalid / 2 conflict / 3 stuck
//   dbg_state   : current FSM state (mon_state_e encoding)
module lamp_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE    = 2,
  parameter int FLASH_HALF  = 4,
  parameter int STUCK_MAX   = 32,
  parameter int RECOVER_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1_in,
  input  logic [2:0] light_M2_in,
  input  logic [2:0] light_Side_in,
  input  logic [2:0] light_M1Turn_in,
  input  logic       clr_fault,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_Side,
  output logic [2:0] light_M1Turn,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] dbg_state
);

  localparam int DW = 4;
  localparam int SW = $clog2(STUCK_MAX + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam int RW = $clog2(RECOVER_CYC + 1);

  localparam logic [DW-1:0] DEBOUNCE_C = DW'(DEBOUNCE);
  localparam logic [SW-1:0] STUCK_C    = SW'(STUCK_MAX);
  localparam logic [FW-1:0] FLASH_C    = FW'(FLASH_HALF);
  localparam logic [RW-1:0] RECOVER_C  = RW'(RECOVER_CYC);

  mon_state_e    state_q, state_d;
  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic [SW-1:0] stuck_q, stuck_d, stuck_inc;
  logic [RW-1:0] rec_q, rec_d, rec_inc;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_on_q, flash_on_d;
  logic [11:0]   prev_q, prev_d;
  logic [11:0]   lamps_q, lamps_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  logic [11:0]   in_bundle;
  logic          invalid, conflict, faulty;
  logic [1:0]    cause;
  logic          deb_hit, stuck_hit, rec_done, enter_fault;

  assign in_bundle = {light_M1_in, light_M2_in, light_Side_in, light_M1Turn_in};

  lamp_conflict_check u_check (
    .m1       (light_M1_in),
    .m2       (light_M2_in),
    .side     (light_Side_in),
    .m1_turn  (light_M1Turn_in),
    .invalid  (invalid),
    .conflict (conflict)
  );

  // Counter increments and the conditions derived from them. All counters
  // saturate rather than wrap.
  always_comb begin
    faulty    = invalid || conflict;
    cause     = invalid ? FC_INVALID : FC_CONFLICT;
    deb_inc   = (deb_q == {DW{1'b1}}) ? deb_q : deb_q + DW'(1);
    rec_inc   = (rec_q == RECOVER_C) ? rec_q : rec_q + RW'(1);
    if (in_bundle != prev_q) begin
      stuck_inc = '0;
    end else begin
      stuck_inc = (stuck_q == STUCK_C) ? stuck_q : stuck_q + SW'(1);
    end
    // deb_q is zero in MONITOR, so this also covers DEBOUNCE=1 there.
    deb_hit   = faulty && (deb_inc >= DEBOUNCE_C);
    stuck_hit = (state_q == ST_MONITOR) && (stuck_inc == STUCK_C);
    rec_done  = (rec_inc == RECOVER_C);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_MONITOR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_MONITOR: begin
        if (faulty) begin
          state_d = deb_hit ? ST_FAULT : ST_PENDING;
        end else if (stuck_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_PENDING: begin
        if (!faulty) begin
          state_d = ST_MONITOR;
        end else if (deb_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (clr_fault && !faulty) begin
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (faulty) begin
          state_d = ST_FAULT;
        end else if (rec_done) begin
          state_d = ST_MONITOR;
        end
      end
      default: state_d = ST_MONITOR;
    endcase
  end

  // Output and datapath logic. Outputs are computed from the state being
  // entered, so the lamp drives never reproduce a sample that tripped the
  // monitor.
  always_comb begin
    enter_fault = (state_d == ST_FAULT) && (state_q != ST_FAULT);
    prev_d      = in_bundle;
    deb_d       = (state_d == ST_PENDING) ? deb_inc : '0;
    stuck_d     = ((state_q == ST_MONITOR) && (state_d == ST_MONITOR)) ? stuck_inc : '0;
    rec_d       = ((state_q == ST_RECOVER) && (state_d == ST_RECOVER)) ? rec_inc : '0;

    // flash_cnt counts cycles already shown in the current phase, including
    // the cycle being registered now.
    flash_on_d  = 1'b1;
    flash_cnt_d = '0;
    if (state_d == ST_FAULT) begin
      if (enter_fault) begin
        flash_on_d  = 1'b1;
        flash_cnt_d = FW'(1);
      end else if (flash_cnt_q == FLASH_C) begin
        flash_on_d  = !flash_on_q;
        flash_cnt_d = FW'(1);
      end else begin
        flash_on_d  = flash_on_q;
        flash_cnt_d = flash_cnt_q + FW'(1);
      end
    end

    code_d = code_q;
    if (state_d == ST_MONITOR) begin
      code_d = FC_NONE;
    end else if (enter_fault) begin
      code_d = faulty ? cause : FC_STUCK;
    end

    fault_d = (state_d == ST_FAULT) || (state_d == ST_RECOVER);

    unique case (state_d)
      ST_MONITOR: lamps_d = in_bundle;
      ST_FAULT:   lamps_d = flash_on_d ? {4{RED}} : {4{DARK}};
      default:    lamps_d = {4{RED}};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q       <= '0;
      stuck_q     <= '0;
      rec_q       <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b0;
      prev_q      <= '0;
      lamps_q     <= {4{RED}};
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
    end else begin
      deb_q       <= deb_d;
      stuck_q     <= stuck_d;
      rec_q       <= rec_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      prev_q      <= prev_d;
      lamps_q     <= lamps_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
    end
  end

  assign light_M1     = lamps_q[11:9];
  assign light_M2     = lamps_q[8:6];
  assign light_Side   = lamps_q[5:3];
  assign light_M1Turn = lamps_q[2:0];
  assign fault        = fault_q;
  assign fault_code   = code_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Bench for lamp_conflict_monitor with default parameters.
module tb_lamp_conflict_monitor;
  import traffic_pkg::*;

  localparam int P_DEB   = 2;
  localparam int P_FH    = 4;
  localparam int P_STUCK = 32;
  localparam int P_REC   = 8;

  // Clean, conflict-free phase patterns {M1, M2, Side, M1Turn}
  localparam logic [11:0] PH1 = {GREEN, GREEN, RED, RED};
  localparam logic [11:0] PH2 = {GREEN, YELLOW, RED, RED};
  localparam logic [11:0] PH3 = {GREEN, RED, RED, GREEN};
  localparam logic [11:0] PH4 = {YELLOW, RED, RED, YELLOW};
  localparam logic [11:0] PH5 = {RED, RED, GREEN, RED};
  localparam logic [11:0] PH6 = {RED, RED, YELLOW, RED};
  localparam logic [11:0] CONF = {GREEN, RED, GREEN, RED};
  localparam logic [11:0] ALL_RED = {RED, RED, RED, RED};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] light_M1_in, light_M2_in, light_Side_in, light_M1Turn_in;
  logic       clr_fault = 1'b0;
  logic [2:0] light_M1, light_M2, light_Side, light_M1Turn;
  logic       fault;
  logic [1:0] fault_code;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [14:0] exp_q[$];
  logic [11:0] phase_pat [6];

  // Reference model state
  int          m_state;
  int          m_deb, m_stuck, m_age, m_rec;
  logic [1:0]  m_code;
  logic [11:0] m_prev;

  lamp_conflict_monitor dut (
    .clk             (clk),
    .rst             (rst),
    .light_M1_in     (light_M1_in),
    .light_M2_in     (light_M2_in),
    .light_Side_in   (light_Side_in),
    .light_M1Turn_in (light_M1Turn_in),
    .clr_fault       (clr_fault),
    .light_M1        (light_M1),
    .light_M2        (light_M2),
    .light_Side      (light_Side),
    .light_M1Turn    (light_M1Turn),
    .fault           (fault),
    .fault_code      (fault_code),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit lamp_ok(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  function automatic bit lamp_go(input logic [2:0] l);
    return (l == 3'b010) || (l == 3'b001);
  endfunction

  function automatic logic [14:0] observed();
    return {light_M1, light_M2, light_Side, light_M1Turn, fault, fault_code};
  endfunction

  task automatic model_reset();
    m_state = 0; m_deb = 0; m_stuck = 0; m_age = 0; m_rec = 0;
    m_code = 2'd0; m_prev = 12'h000;
  endtask

  task automatic model_enter_fault(input logic [1:0] c);
    m_state = 2; m_code = c; m_age = 0; m_deb = 0; m_stuck = 0;
  endtask

  // Advance the model by one sample and queue what the DUT must show after
  // the coming clock edge.
  task automatic model_step(input logic [11:0] bun, input logic clr);
    logic [2:0]  a, b, c, d;
    bit          inv, con, bad, same;
    logic [1:0]  why;
    logic [11:0] lamps;
    a = bun[11:9]; b = bun[8:6]; c = bun[5:3]; d = bun[2:0];
    inv  = !(lamp_ok(a) && lamp_ok(b) && lamp_ok(c) && lamp_ok(d));
    con  = (lamp_go(b) && lamp_go(d)) || (lamp_go(a) && lamp_go(c)) ||
           (lamp_go(b) && lamp_go(c)) || (lamp_go(d) && lamp_go(c));
    bad  = inv || con;
    why  = inv ? 2'd1 : 2'd2;
    same = (bun == m_prev);
    m_prev = bun;
    case (m_state)
      0: begin
        if (bad) begin
          m_deb = 1; m_stuck = 0;
          if (m_deb >= P_DEB) model_enter_fault(why);
          else m_state = 1;
        end else begin
          if (!same) m_stuck = 0;
          else if (m_stuck < P_STUCK) m_stuck = m_stuck + 1;
          if (m_stuck >= P_STUCK) model_enter_fault(2'd3);
        end
      end
      1: begin
        if (bad) begin
          m_deb = m_deb + 1;
          if (m_deb >= P_DEB) model_enter_fault(why);
        end else begin
          m_state = 0; m_deb = 0; m_stuck = 0;
        end
      end
      2: begin
        m_age = m_age + 1;
        if (clr && !bad) begin
          m_state = 3; m_rec = 0;
        end
      end
      default: begin
        if (bad) model_enter_fault(why);
        else begin
          m_rec = m_rec + 1;
          if (m_rec >= P_REC) begin
            m_state = 0; m_code = 2'd0; m_stuck = 0;
          end
        end
      end
    endcase
    if (m_state == 0) lamps = bun;
    else if (m_state == 2) lamps = (((m_age / P_FH) % 2) == 0) ? ALL_RED : 12'h000;
    else lamps = ALL_RED;
    exp_q.push_back({lamps, (m_state == 2 || m_state == 3), m_code});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [11:0] bun, input logic clr);
    {light_M1_in, light_M2_in, light_Side_in, light_M1Turn_in} = bun;
    clr_fault = clr;
    model_step(bun, clr);
    @(posedge clk);
    #1;
    clr_fault = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [14:0] e;
    {light_M1_in, light_M2_in, light_Side_in, light_M1Turn_in} = PH1;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (observed() !== {ALL_RED, 1'b0, FC_NONE} || dbg_state !== ST_MONITOR) begin
      n_fail++;
      $display("FAIL reset_values: got %h state %0d, exp %h state 0", observed(), dbg_state,
               {ALL_RED, 1'b0, FC_NONE});
    end
    rst = 1'b1;
    step(PH1, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (observed() !== e || e[14:3] !== PH1) begin
      n_fail++;
      $display("FAIL first_cycle_pass: got %h exp %h", observed(), e);
    end
  endtask

  task automatic test_normal_cycle();
    logic [14:0] e;
    int len;
    for (int p = 0; p < 6; p++) begin
      case (p)
        0: len = 20; 1: len = 5; 2: len = 15; 3: len = 5; 4: len = 10; default: len = 5;
      endcase
      for (int i = 0; i < len; i++) begin
        step(phase_pat[p], 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (observed() !== e || fault !== 1'b0) begin
          n_fail++;
          $display("FAIL normal_cycle p%0d c%0d: got %h exp %h", p, i, observed(), e);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [14:0] e;
    logic [11:0] g;
    g = PH1;
    g[8:6] = DARK;
    for (int i = 0; i < 4; i++) begin
      step((i == 0) ? g : phase_pat[i % 2], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e || fault !== 1'b0 ||
          ((i == 0) && light_M2 !== RED) || ((i > 0) && dbg_state !== ST_MONITOR)) begin
        n_fail++;
        $display("FAIL glitch c%0d: got %h exp %h", i, observed(), e);
      end
    end
  endtask

  // Two conflicting samples, then clean inputs while the flash runs.
  task automatic test_conflict();
    logic [14:0] e;
    logic        want_red;
    for (int k = 0; k < 13; k++) begin
      step((k < 2) ? CONF : PH5, 1'b0);
      e = exp_q.pop_front();
      want_red = (k < 5) || (k >= 9);
      n_checks++;
      if (observed() !== e ||
          ({light_M1, light_M2, light_Side, light_M1Turn} !== (want_red ? ALL_RED : 12'h000)) ||
          ((k == 0) && dbg_state !== ST_PENDING) ||
          ((k >= 1) && (fault !== 1'b1 || fault_code !== FC_CONFLICT))) begin
        n_fail++;
        $display("FAIL conflict_flash k%0d: got %h state %0d exp %h", k, observed(), dbg_state, e);
      end
    end
  endtask

  // From FAULT: clear with a clean sample, then RECOVER_CYC clean cycles.
  task automatic test_clear_recover();
    logic [14:0] e;
    for (int i = 0; i <= P_REC; i++) begin
      step(phase_pat[i % 2], (i == 0));
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e ||
          ((i < P_REC) && (fault !== 1'b1 || dbg_state !== ST_RECOVER)) ||
          ((i == P_REC) && (fault !== 1'b0 || fault_code !== FC_NONE || dbg_state !== ST_MONITOR))) begin
        n_fail++;
        $display("FAIL clear_recover c%0d: got %h state %0d exp %h", i, observed(), dbg_state, e);
      end
    end
  endtask

  // Fault, clear, then a conflict on the fifth RECOVER cycle; clr is also
  // tried on a faulty sample in FAULT, where it must be ignored.
  task automatic test_recover_conflict();
    logic [14:0] e;
    logic [11:0] bun;
    logic        clr;
    for (int i = 0; i < 14; i++) begin
      clr = 1'b0;
      case (i)
        0, 1:    bun = CONF;
        2, 3:    bun = PH1;
        4: begin bun = PH2; clr = 1'b1; end
        9:       bun = CONF;
        11: begin bun = CONF; clr = 1'b1; end
        default: bun = phase_pat[i % 6];
      endcase
      step(bun, clr);
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e ||
          ((i == 9) && (fault_code !== FC_CONFLICT || dbg_state !== ST_FAULT ||
                        light_M1 !== RED)) ||
          ((i == 11) && dbg_state !== ST_FAULT)) begin
        n_fail++;
        $display("FAIL recover_conflict c%0d: got %h state %0d exp %h", i, observed(), dbg_state, e);
      end
    end
  endtask

  // Invalid and conflicting together: invalid wins.
  task automatic test_invalid();
    logic [14:0] e;
    logic [11:0] bad;
    bad = {3'b011, GREEN, GREEN, RED};
    for (int i = 0; i < 4; i++) begin
      step((i < 2) ? bad : PH6, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e || ((i >= 1) && fault_code !== FC_INVALID)) begin
        n_fail++;
        $display("FAIL invalid_priority c%0d: got %h exp %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_stuck();
    logic [14:0] e;
    for (int i = 0; i < 40; i++) begin
      step(PH3, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL stuck c%0d: got %h exp %h", i, observed(), e);
      end
    end
    n_checks++;
    if (fault !== 1'b1 || fault_code !== FC_STUCK) begin
      n_fail++;
      $display("FAIL stuck_code: got fault %b code %0d exp fault 1 code 3", fault, fault_code);
    end
  endtask

  task automatic test_clr_in_monitor();
    logic [14:0] e;
    for (int i = 0; i < 6; i++) begin
      step(phase_pat[(i % 2) + 4], 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e || fault !== 1'b0 || dbg_state !== ST_MONITOR) begin
        n_fail++;
        $display("FAIL clr_in_monitor c%0d: got %h exp %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_reset_mid_fault();
    logic [14:0] e;
    for (int i = 0; i < 4; i++) begin
      step(CONF, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL rst_fault_entry c%0d: got %h exp %h", i, observed(), e);
      end
    end
    rst = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (observed() !== {ALL_RED, 1'b0, FC_NONE} || dbg_state !== ST_MONITOR) begin
      n_fail++;
      $display("FAIL rst_async: got %h state %0d exp %h", observed(), dbg_state, {ALL_RED, 3'b000});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(phase_pat[i + 2], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e || {light_M1, light_M2, light_Side, light_M1Turn} !== phase_pat[i + 2]) begin
        n_fail++;
        $display("FAIL rst_release_pass c%0d: got %h exp %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [14:0] e;
    logic [11:0] bun;
    for (int i = 0; i < 400; i++) begin
      bun = phase_pat[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) bun = 12'($urandom_range(0, 4095));
      step(bun, ($urandom_range(0, 3) == 0));
      e = exp_q.pop_front();
      n_checks++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL random c%0d: in %h got %h exp %h", i, bun, observed(), e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    phase_pat[0] = PH1; phase_pat[1] = PH2; phase_pat[2] = PH3;
    phase_pat[3] = PH4; phase_pat[4] = PH5; phase_pat[5] = PH6;
    #1;
    test_reset();
    test_normal_cycle();
    test_glitch();
    test_conflict();
    test_clear_recover();
    test_recover_conflict();
    test_clear_recover();
    test_invalid();
    test_clear_recover();
    test_stuck();
    test_clear_recover();
    test_clr_in_monitor();
    test_reset_mid_fault();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
